step_pulse_gen: RTL and testbench

Command-driven step/direction pulse generator that produces the `rotate_pulse` / `direction` pair consumed by the stepper motor driver block. It accepts a move command (direction, step count, step period) over a valid/ready handshake. It emits exactly that many step pulses with guaranteed direction setup time and minimum high width, and tracks an absolute signed position. It sits between the host/control logic and the motor driver on the TangNano9K motor driver board.

---
 rtl/step_pulse_gen.sv | 203 ++++++++++++++++++++
 tb/tb_step_pulse_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Command-driven step/direction pulse generator feeding the stepper driver.
//   A move command (dir, steps, period) is accepted over valid/ready; the block
//   then holds direction for DIR_SETUP_CYC clocks and emits `cmd_steps`
//   pulses, each PULSE_HIGH_CYC clocks high, rising every effective period
//   (cmd_period clamped up to 2*PULSE_HIGH_CYC). A signed absolute position is
//   tracked across moves and cleared only by reset.
//
// Ports
//   clk, rst_n        system clock, async active-low reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_dir           1 = forward (+1/step), 0 = reverse (-1/step)
//   cmd_steps         pulse count, 0 legal
//   cmd_period        clocks between rising edges (clamped)
//   abort             level; ends the move cleanly (never truncates a pulse)
//   rotate_pulse      step output
//   direction         direction output, changes only on accept
//   busy              move in progress
//   done              1-cycle pulse at end of each accepted command
//   aborted           1-cycle pulse with done when the move was aborted
//   steps_remaining   pulses not yet started
//   position          signed absolute position (wraps)
//
// All outputs are registered; the comb block computes next-state values and
// the output flops are loaded from those.
module step_pulse_gen #(
  parameter int DIR_SETUP_CYC  = 4,
  parameter int PULSE_HIGH_CYC = 8,
  parameter int COUNT_W        = 16,
  parameter int PERIOD_W       = 16,
  parameter int POS_W          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic               abort,
  output logic               rotate_pulse,
  output logic               direction,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] steps_remaining,
  output logic [POS_W-1:0]   position
);

  // Phase counter must hold both the setup/high lengths (<=255) and a full
  // clamped period.
  localparam int CNT_W = (PERIOD_W + 1 > 9) ? PERIOD_W + 1 : 9;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(PULSE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_C   = CNT_W'(PULSE_HIGH_CYC);
  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(2 * PULSE_HIGH_CYC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // clocks left in current phase, minus 1
  logic [CNT_W-1:0]   per_q, per_d;     // effective period of the active move
  logic [CNT_W-1:0]   per_in;
  logic               fin_wait_q, fin_wait_d; // zero-step move: one quiet FINISH cycle before done
  logic               abt_q, abt_d;     // move is ending because of abort
  logic               pend_q, pend_d;   // abort seen during HIGH, honoured at its end
  logic               dir_d;
  logic [COUNT_W-1:0] rem_d;
  logic [POS_W-1:0]   pos_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    fin_wait_d = fin_wait_q;
    abt_d      = abt_q;
    pend_d     = pend_q;
    dir_d      = direction;
    rem_d      = steps_remaining;
    pos_d      = position;

    per_in = CNT_W'(cmd_period);
    if (per_in < MIN_PER) per_in = MIN_PER;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          dir_d  = cmd_dir;
          rem_d  = cmd_steps;
          per_d  = per_in;
          abt_d  = 1'b0;
          pend_d = 1'b0;
          if (cmd_steps == '0) begin
            // done lands one clock after accept, so FINISH is held one
            // extra (silent) cycle.
            state_d    = FINISH;
            fin_wait_d = 1'b1;
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end

      SETUP: begin
        if (abort) begin
          state_d    = FINISH;
          abt_d      = 1'b1;
          fin_wait_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = HIGH_LD;
          pend_d  = 1'b0;
          rem_d   = steps_remaining - COUNT_W'(1);
          pos_d   = direction ? position + POS_W'(1) : position - POS_W'(1);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      HIGH: begin
        // A pulse always completes its full width, abort or not.
        if (cnt_q == '0) begin
          if (abort || pend_q) begin
            state_d    = FINISH;
            abt_d      = 1'b1;
            fin_wait_d = 1'b0;
          end else begin
            state_d = LOW;
            cnt_d   = per_q - HIGH_C - ONE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
          if (abort) pend_d = 1'b1;
        end
      end

      LOW: begin
        if (abort) begin
          state_d    = FINISH;
          abt_d      = 1'b1;
          fin_wait_d = 1'b0;
        end else if (cnt_q == '0) begin
          if (steps_remaining != '0) begin
            state_d = HIGH;
            cnt_d   = HIGH_LD;
            pend_d  = 1'b0;
            rem_d   = steps_remaining - COUNT_W'(1);
            pos_d   = direction ? position + POS_W'(1) : position - POS_W'(1);
          end else begin
            state_d    = FINISH;
            fin_wait_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      FINISH: begin
        if (fin_wait_q) fin_wait_d = 1'b0;
        else            state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      per_q           <= '0;
      fin_wait_q      <= 1'b0;
      abt_q           <= 1'b0;
      pend_q          <= 1'b0;
      direction       <= 1'b0;
      steps_remaining <= '0;
      position        <= '0;
      rotate_pulse    <= 1'b0;
      busy            <= 1'b0;
      cmd_ready       <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      per_q           <= per_d;
      fin_wait_q      <= fin_wait_d;
      abt_q           <= abt_d;
      pend_q          <= pend_d;
      direction       <= dir_d;
      steps_remaining <= rem_d;
      position        <= pos_d;
      rotate_pulse    <= (state_d == HIGH);
      busy            <= (state_d != IDLE);
      cmd_ready       <= (state_d == IDLE);
      done            <= (state_d == FINISH) && !fin_wait_d;
      aborted         <= (state_d == FINISH) && !fin_wait_d && abt_d;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen: directed moves from the test plan plus random
// moves, each checked cycle by cycle against a timeline computed from the
// move parameters (setup, period, pulse width, abort point).
module tb_step_pulse_gen;
  localparam int D = 4;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        cmd_ready, rotate_pulse, direction, busy, done, aborted;
  logic [15:0] steps_remaining;
  logic [31:0] position;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] pos_m = '0;

  step_pulse_gen dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
    .rotate_pulse(rotate_pulse), .direction(direction), .busy(busy),
    .done(done), .aborted(aborted),
    .steps_remaining(steps_remaining), .position(position)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one move. ab = cycle (relative to accept edge) at which abort is
  // raised, -1 for none. With keep set, cmd_valid stays high after accept and
  // the next command's fields are presented while this move runs.
  task automatic run_cmd(input logic d, input int s, input int p, input int ab,
                         input logic keep, input logic nd, input int ns, input int np);
    int   pe, done_c, sent, waited;
    logic was_ab, rot;
    pe = (p < 2 * H) ? 2 * H : p;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = 16'(s);
    cmd_period = 16'(p);
    @(posedge clk);

    // Expected end of move
    was_ab = 1'b0;
    if (s == 0) begin
      done_c = 1;
      sent   = 0;
    end else begin
      done_c = D + s * pe;
      sent   = s;
    end
    if (ab >= 0 && s > 0 && ab < D + s * pe) begin
      int r;
      was_ab = 1'b1;
      r = ab - D;
      if (r < 0) begin
        done_c = ab + 1;
        sent   = 0;
      end else if ((r % pe) < H) begin
        done_c = D + (r / pe) * pe + H;  // pulse finishes its width
        sent   = r / pe + 1;
      end else begin
        done_c = ab + 1;
        sent   = r / pe + 1;
      end
    end

    #1;
    if (!keep) cmd_valid = 1'b0;
    else begin
      cmd_dir    = nd;
      cmd_steps  = 16'(ns);
      cmd_period = 16'(np);
    end

    for (int c = 0; c <= done_c + 1; c++) begin
      int r;
      @(negedge clk);
      r   = c - D;
      rot = (c < done_c) && (r >= 0) && ((r / pe) < sent) && ((r % pe) < H);
      chk("rotate_pulse", rotate_pulse, rot);
      chk("done", done, c == done_c);
      chk("aborted", aborted, (c == done_c) && was_ab);
      chk("busy", busy, c <= done_c);
      chk("cmd_ready", cmd_ready, c > done_c);
      chk("direction", direction, d);
      if (ab >= 0 && c == ab) abort = 1'b1;
    end
    abort = 1'b0;
    if (d) pos_m = pos_m + 32'(sent);
    else   pos_m = pos_m - 32'(sent);
    chk("position", position, pos_m);
    chk("steps_remaining", steps_remaining, 16'(s - sent));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rotate", rotate_pulse, 1'b0);
    chk("rst_direction", direction, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_steps", steps_remaining, 16'd0);
    chk("rst_position", position, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready_low", cmd_ready, 1'b0);
    @(posedge clk);
    #1 chk("rel_ready_high", cmd_ready, 1'b1);

    // Basic move, zero-step move, clamped period, abort mid-high
    run_cmd(1'b1, 3, 20, -1, 1'b0, 1'b0, 0, 0);
    chk("pos_after_3", position, 32'd3);
    run_cmd(1'b0, 0, 20, -1, 1'b0, 1'b0, 0, 0);
    chk("pos_after_0", position, 32'd3);
    run_cmd(1'b1, 2, 5, -1, 1'b0, 1'b0, 0, 0);
    run_cmd(1'b1, 10, 20, D + 20 + 3, 1'b0, 1'b0, 0, 0);
    chk("abort_steps_left", steps_remaining, 16'd8);

    // Reset in the middle of a pulse
    while (cmd_ready !== 1'b1) @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10; cmd_period = 16'd20;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (D + 3) @(negedge clk);
    chk("midhigh_rotate", rotate_pulse, 1'b1);
    chk("midhigh_pos", position, pos_m + 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rotate", rotate_pulse, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_position", position, 32'd0);
    pos_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel2_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    chk("rel2_ready_high", cmd_ready, 1'b1);

    // Back-to-back +5 then -7 with cmd_valid held through the first move
    run_cmd(1'b1, 5, 20, -1, 1'b1, 1'b0, 7, 20);
    run_cmd(1'b0, 7, 20, -1, 1'b0, 1'b0, 0, 0);
    chk("pos_minus2", position, 32'hFFFF_FFFE);

    // Random moves, some aborted at a random point
    for (int i = 0; i < 12; i++) begin
      logic d;
      int   s, p, pe, ab;
      d  = 1'($urandom_range(0, 1));
      s  = $urandom_range(0, 5);
      p  = $urandom_range(0, 40);
      pe = (p < 2 * H) ? 2 * H : p;
      ab = -1;
      if (s > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(0, D + s * pe - 1);
      run_cmd(d, s, p, ab, 1'b0, 1'b0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
